// File: rtl/if_stage_if.sv
// Instruction memory fetch bus: valid/ready request, valid-only response.
// The fetch side drives the request and the memory side answers it.
interface if_stage_if #(
    parameter int ADDR_W = 64
) ();
    logic              inst_req_valid;
    logic              inst_req_ready;
    logic [ADDR_W-1:0] inst_addr;
    logic              inst_resp_valid;
    logic [31:0]       inst_resp_data;

    modport master (
        output inst_req_valid,
        output inst_addr,
        input  inst_req_ready,
        input  inst_resp_valid,
        input  inst_resp_data
    );

    modport slave (
        input  inst_req_valid,
        input  inst_addr,
        output inst_req_ready,
        output inst_resp_valid,
        output inst_resp_data
    );
endinterface

// File: rtl/if_stage.sv
// Instruction fetch stage: owns the PC, one outstanding fetch, output register.
// Optional IF_PERF_CNT_EN adds fetch and flush event counters.
`ifndef DATA_WIDTH
`define DATA_WIDTH 64
`endif

module if_stage #(
    parameter int                ADDR_W   = `DATA_WIDTH,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(64'h0000_0000_8000_0000)
) (
    input  logic              clk,
    input  logic              rst_n,
    if_stage_if.master        mem,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              id_ready,
    output logic              if_valid,
    output logic [ADDR_W-1:0] if_pc,
    output logic [31:0]       if_inst
`ifdef IF_PERF_CNT_EN
    ,
    output logic [63:0]       perf_fetch_cnt,
    output logic [63:0]       perf_flush_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DRAIN
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic              out_free;
    logic              req_fire;
    logic              resp_write;

    // Request only when the output register can take the answer.
    assign out_free = !if_valid || id_ready;
    assign mem.inst_req_valid = (state == REQ) && out_free;
    assign mem.inst_addr = pc;
    assign req_fire = mem.inst_req_valid && mem.inst_req_ready;
    assign resp_write = (state == WAIT) && mem.inst_resp_valid
                        && !redirect_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            pc       <= RESET_PC;
            if_valid <= 1'b0;
            if_pc    <= '0;
            if_inst  <= '0;
        end else begin
            unique case (state)
                IDLE: state <= REQ;
                REQ: begin
                    if (req_fire)
                        state <= redirect_valid ? DRAIN : WAIT;
                end
                WAIT: begin
                    if (mem.inst_resp_valid)
                        state <= REQ;
                    else if (redirect_valid)
                        state <= DRAIN;
                end
                DRAIN: begin
                    if (mem.inst_resp_valid)
                        state <= REQ;
                end
            endcase

            if (redirect_valid) begin
                pc       <= redirect_pc & ~(ADDR_W'(3));
                if_valid <= 1'b0;
            end else if (resp_write) begin
                pc       <= pc + ADDR_W'(4);
                if_valid <= 1'b1;
                if_pc    <= pc;
                if_inst  <= mem.inst_resp_data;
            end else if (if_valid && id_ready) begin
                if_valid <= 1'b0;
            end
        end
    end

`ifdef IF_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetch_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (resp_write)
                perf_fetch_cnt <= perf_fetch_cnt + 64'd1;
            if (redirect_valid)
                perf_flush_cnt <= perf_flush_cnt + 64'd1;
        end
    end
`endif

endmodule

// File: tb/tb_if_stage.sv
// Randomized bench for if_stage against a transaction-level fetch model.
// Directed phases pin reset, throughput, redirect and async reset cases.
`timescale 1ns/1ps
module tb_if_stage;
    localparam int          AW  = 64;
    localparam logic [63:0] RPC = 64'h0000_0000_8000_0000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    if_stage_if #(.ADDR_W(AW)) mem ();
    logic          redirect_valid;
    logic [63:0]   redirect_pc;
    logic          id_ready;
    logic          if_valid;
    logic [63:0]   if_pc;
    logic [31:0]   if_inst;
`ifdef IF_PERF_CNT_EN
    logic [63:0]   perf_fetch_cnt;
    logic [63:0]   perf_flush_cnt;
`endif

    if_stage #(.ADDR_W(AW), .RESET_PC(RPC)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .mem            (mem),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_ready       (id_ready),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .if_inst        (if_inst)
`ifdef IF_PERF_CNT_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_flush_cnt (perf_flush_cnt)
`endif
    );

    int vectors = 0;
    int fails = 0;
    int cyc = 0;

    // Model: a fetch is either absent, outstanding-for-use or outstanding-to-drop.
    bit          m_started, m_outst, m_discard;
    logic [63:0] m_pc, m_opc;
    bit          m_ov;
    logic [31:0] m_oinst;
    logic [63:0] m_fetch, m_flush;

    // Memory: one pending answer, delivered after a countdown.
    bit          pend;
    int          cnt;

    int          p_rdy, p_idr, p_redir, p_stray, d_min, d_max;
    bit          fix_rpc, fix_data;
    logic [63:0] rpc_fixed;
    logic [31:0] data_fixed;
    bit          rel_pending;

    bit          got_req;
    logic [63:0] req_addr;
    logic [63:0] vq[$];
    int          tq[$];

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at cycle %0d",
                     nm, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_started = 0; m_outst = 0; m_discard = 0;
        m_pc = RPC; m_ov = 0; m_opc = '0; m_oinst = '0;
        m_fetch = '0; m_flush = '0;
    endtask

    task automatic cycle();
        bit          rdy, idr, rv, resp, exp_req, hs;
        logic [63:0] rpc;
        logic [31:0] data;
        @(negedge clk);
        if (rel_pending) begin
            rst_n = 1'b1;
            rel_pending = 0;
        end
        rdy = ($urandom % 100) < p_rdy;
        idr = ($urandom % 100) < p_idr;
        rv  = ($urandom % 100) < p_redir;
        if (fix_rpc) rpc = rpc_fixed;
        else if ($urandom % 4 == 0) rpc = 64'hFFFF_FFFF_FFFF_FFF8 + 64'($urandom % 8);
        else rpc = {$urandom, $urandom};
        data = fix_data ? data_fixed : $urandom;
        if (pend) begin
            cnt--;
            resp = (cnt == 0);
        end else begin
            resp = ($urandom % 100) < p_stray;
        end
        mem.inst_req_ready = rdy;
        id_ready = idr;
        redirect_valid = rv;
        redirect_pc = rpc;
        mem.inst_resp_valid = resp;
        mem.inst_resp_data = data;
        #1;
        exp_req = m_started && !m_outst && (!m_ov || idr);
        chk("req_valid", 64'(mem.inst_req_valid), 64'(exp_req));
        chk("inst_addr", mem.inst_addr, m_pc);
        chk("if_valid", 64'(if_valid), 64'(m_ov));
        chk("if_pc", if_pc, m_opc);
        chk("if_inst", 64'(if_inst), 64'(m_oinst));
`ifdef IF_PERF_CNT_EN
        chk("perf_fetch", perf_fetch_cnt, m_fetch);
        chk("perf_flush", perf_flush_cnt, m_flush);
`endif
        if (mem.inst_req_valid && !got_req) begin
            got_req = 1;
            req_addr = mem.inst_addr;
        end
        if (if_valid) begin
            vq.push_back(if_pc);
            tq.push_back(cyc);
        end
        hs = exp_req && rdy;
        if (rv) begin
            m_pc = {rpc[63:2], 2'b00};
            m_ov = 0;
            m_flush++;
            if (m_outst && resp) begin
                m_outst = 0; m_discard = 0;
            end else if (m_outst) begin
                m_discard = 1;
            end
            if (hs) begin m_outst = 1; m_discard = 1; end
        end else begin
            if (m_outst && resp && !m_discard) begin
                m_ov = 1; m_opc = m_pc; m_oinst = data;
                m_pc = m_pc + 64'd4; m_fetch++;
            end else if (m_ov && idr) begin
                m_ov = 0;
            end
            if (m_outst && resp) begin m_outst = 0; m_discard = 0; end
            if (hs) begin m_outst = 1; m_discard = 0; end
        end
        m_started = 1;
        if (resp && pend) pend = 0;
        if (hs) begin
            pend = 1;
            cnt = $urandom_range(d_max, d_min);
        end
        @(posedge clk);
        cyc++;
    endtask

    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_req_valid", 64'(mem.inst_req_valid), 64'd0);
        chk("rst_inst_addr", mem.inst_addr, RPC);
        chk("rst_if_valid", 64'(if_valid), 64'd0);
        chk("rst_if_pc", if_pc, 64'd0);
        chk("rst_if_inst", 64'(if_inst), 64'd0);
        model_reset();
        @(posedge clk);
        rel_pending = 1;
    endtask

    initial begin
        int n;
        mem.inst_req_ready = 0; mem.inst_resp_valid = 0;
        mem.inst_resp_data = '0;
        redirect_valid = 0; redirect_pc = '0; id_ready = 0;
        pend = 0; cnt = 0; fix_rpc = 0; fix_data = 0;
        rpc_fixed = '0; data_fixed = '0;
        model_reset();
        repeat (3) @(posedge clk);

        // Zero-wait memory, decode always ready.
        p_rdy = 100; p_idr = 100; p_redir = 0; p_stray = 0;
        d_min = 1; d_max = 1;
        got_req = 0; req_addr = '0;
        vq.delete(); tq.delete();
        rel_pending = 1;
        repeat (11) cycle();
        chk("first_req_seen", 64'(got_req), 64'd1);
        chk("first_addr", req_addr, 64'h8000_0000);
        chk("valid_count", 64'(vq.size()), 64'd4);
        if (vq.size() >= 3) begin
            chk("pc0", vq[0], 64'h8000_0000);
            chk("pc1", vq[1], 64'h8000_0004);
            chk("pc2", vq[2], 64'h8000_0008);
            chk("period", 64'(tq[1] - tq[0]), 64'd2);
            chk("first_valid_cycle", 64'(tq[0]), 64'd3);
        end

        // Two redirect cycles while waiting; the late answer must be dropped.
        d_min = 3; d_max = 3;
        fix_data = 1; data_fixed = 32'hDEAD_BEEF;
        n = 0;
        while (!(m_outst && !m_discard) && n < 20) begin
            cycle(); n++;
        end
        chk("reach_wait", 64'(m_outst && !m_discard), 64'd1);
        p_redir = 100; fix_rpc = 1; rpc_fixed = 64'h8000_0103;
        cycle();
        cycle();
        p_redir = 0;
        #1;
        chk("redir_if_valid", 64'(if_valid), 64'd0);
`ifdef IF_PERF_CNT_EN
        chk("perf_fetch_lit", perf_fetch_cnt, 64'd5);
        chk("perf_flush_lit", perf_flush_cnt, 64'd2);
`endif
        got_req = 0;
        n = 0;
        while (!got_req && n < 20) begin
            cycle(); n++;
        end
        chk("redir_req_seen", 64'(got_req), 64'd1);
        chk("redir_addr", req_addr, 64'h8000_0100);
        chk("no_deadbeef", 64'(if_valid && if_inst == 32'hDEAD_BEEF), 64'd0);
        fix_rpc = 0; fix_data = 0;

        // Asynchronous reset while a fetch is outstanding.
        n = 0;
        while (!(m_outst && !m_discard) && n < 20) begin
            cycle(); n++;
        end
        do_reset();
        d_min = 1; d_max = 2;
        got_req = 0;
        repeat (6) cycle();
        chk("post_rst_addr", req_addr, RPC);

        // Random traffic with stalls, redirects, strays and resets.
        p_rdy = 60; p_idr = 70; p_redir = 5; p_stray = 5;
        d_min = 1; d_max = 3;
        for (int i = 0; i < 4000; i++) begin
            cycle();
            if ($urandom % 400 == 0) do_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule
